// File: rtl/axi_wr_arb_pkg.sv
// Shared types for the AXI write-channel arbiter: FSM state encoding and
// the AXI B-channel response codes used on the requester side.
package axi_wr_arb_pkg;

    // One transaction walks IDLE -> ADDR -> DATA -> RESP -> IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_e;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

endpackage

// File: rtl/axi_wr_arbiter_rr_pick.sv
// rr_pick: combinational one-hot request picker.
// Default: round-robin, the first requester at or after ptr wins.
// With AXI_WR_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins,
// and the ptr input does not exist.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
`ifndef AXI_WR_ARB_FIXED_PRIO_EN
    input  logic [$clog2(N)-1:0] ptr,
`endif
    output logic [N-1:0]         gnt
);

    logic found;

`ifdef AXI_WR_ARB_FIXED_PRIO_EN
    // Priority encoder: first set bit from index 0 upwards.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        gnt   = '0;
        found = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!found && req[j]) begin
                gnt[j] = 1'b1;
                found  = 1'b1;
            end
        end
    end
`else
    // Round-robin: scan offsets 0..N-1 from ptr; only constant indices are
    // used so the search unrolls into a flat compare tree.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int ofs = 0; ofs < N; ofs++) begin
            for (int j = 0; j < N; j++) begin
                if (!found && req[j] && (((j - int'(ptr) + N) % N) == ofs)) begin
                    gnt[j] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: rtl/axi_wr_arbiter.sv
// axi_wr_arbiter: shares one AXI write master (AW/W/B) between NREQ
// requesters. A granted requester owns the channel from AW through B;
// wlast is generated from an internal beat counter.
// Build option: AXI_WR_ARB_FIXED_PRIO_EN selects fixed priority (lowest
// index wins) instead of round-robin.
module axi_wr_arbiter
    import axi_wr_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int AW   = 32,
    parameter int DW   = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ*AW-1:0]    req_awaddr,
    input  logic [NREQ*8-1:0]     req_awlen,
    input  logic [NREQ*3-1:0]     req_awsize,
    input  logic [NREQ*2-1:0]     req_awburst,
    input  logic [NREQ-1:0]       req_awvalid,
    output logic [NREQ-1:0]       req_awready,
    input  logic [NREQ*DW-1:0]    req_wdata,
    input  logic [NREQ*DW/8-1:0]  req_wstrb,
    input  logic [NREQ-1:0]       req_wvalid,
    output logic [NREQ-1:0]       req_wready,
    output logic [NREQ-1:0]       req_bvalid,
    output logic [1:0]            req_bresp,
    input  logic [NREQ-1:0]       req_bready,
    output logic [AW-1:0]         m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DW-1:0]         m_axi_wdata,
    output logic [DW/8-1:0]       m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [NREQ-1:0]       grant
);

    localparam int SW = DW / 8;
    localparam int PW = $clog2(NREQ);

    state_e            state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [7:0]        beat_q,  beat_d;
    logic [7:0]        len_q,   len_d;
    logic [NREQ-1:0]   pick_gnt;
`ifndef AXI_WR_ARB_FIXED_PRIO_EN
    logic [PW-1:0]     ptr_q,   ptr_d;
`endif

    rr_pick #(.N(NREQ)) u_pick (
        .req (req_awvalid),
`ifndef AXI_WR_ARB_FIXED_PRIO_EN
        .ptr (ptr_q),
`endif
        .gnt (pick_gnt)
    );

    assign grant = grant_q;

    // Channel mux: route the granted requester onto the shared port; every
    // handshake signal is qualified by the state that owns that channel.
    always_comb begin
        m_axi_awaddr  = '0;
        m_axi_awlen   = '0;
        m_axi_awsize  = '0;
        m_axi_awburst = '0;
        m_axi_wdata   = '0;
        m_axi_wstrb   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) begin
                m_axi_awaddr  = req_awaddr[i*AW +: AW];
                m_axi_awlen   = req_awlen[i*8 +: 8];
                m_axi_awsize  = req_awsize[i*3 +: 3];
                m_axi_awburst = req_awburst[i*2 +: 2];
                m_axi_wdata   = req_wdata[i*DW +: DW];
                m_axi_wstrb   = req_wstrb[i*SW +: SW];
            end
        end
        m_axi_awvalid = (state_q == ADDR) && |(req_awvalid & grant_q);
        req_awready   = (state_q == ADDR) ? (grant_q & {NREQ{m_axi_awready}}) : '0;
        m_axi_wvalid  = (state_q == DATA) && |(req_wvalid & grant_q);
        m_axi_wlast   = (state_q == DATA) && (beat_q == len_q);
        req_wready    = (state_q == DATA) ? (grant_q & {NREQ{m_axi_wready}}) : '0;
        req_bvalid    = (state_q == RESP) ? (grant_q & {NREQ{m_axi_bvalid}}) : '0;
        req_bresp     = (state_q == RESP) ? m_axi_bresp : OKAY;
        m_axi_bready  = (state_q == RESP) && |(req_bready & grant_q);
    end

    // Next-state logic: grant on request, advance on each channel handshake.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        beat_d  = beat_q;
        len_d   = len_q;
`ifndef AXI_WR_ARB_FIXED_PRIO_EN
        ptr_d   = ptr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (|req_awvalid) begin
                    grant_d = pick_gnt;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (m_axi_awvalid && m_axi_awready) begin
                    len_d   = m_axi_awlen;
                    beat_d  = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (m_axi_wvalid && m_axi_wready) begin
                    beat_d = beat_q + 8'd1;
                    if (m_axi_wlast) begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (m_axi_bvalid && m_axi_bready) begin
                    grant_d = '0;
                    state_d = IDLE;
`ifndef AXI_WR_ARB_FIXED_PRIO_EN
                    for (int i = 0; i < NREQ; i++) begin
                        if (grant_q[i]) begin
                            ptr_d = PW'((i + 1) % NREQ);
                        end
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            beat_q  <= '0;
            len_q   <= '0;
`ifndef AXI_WR_ARB_FIXED_PRIO_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            beat_q  <= beat_d;
            len_q   <= len_d;
`ifndef AXI_WR_ARB_FIXED_PRIO_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed self-checking bench for axi_wr_arbiter (NREQ=4, AW=32, DW=64).
// Honours AXI_WR_ARB_FIXED_PRIO_EN for the expected grant order.
module tb_axi_wr_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 32;
    localparam int DW   = 64;
    localparam int SW   = DW / 8;

    logic                 clk;
    logic                 rst;
    logic [NREQ*AW-1:0]   req_awaddr;
    logic [NREQ*8-1:0]    req_awlen;
    logic [NREQ*3-1:0]    req_awsize;
    logic [NREQ*2-1:0]    req_awburst;
    logic [NREQ-1:0]      req_awvalid;
    logic [NREQ-1:0]      req_awready;
    logic [NREQ*DW-1:0]   req_wdata;
    logic [NREQ*SW-1:0]   req_wstrb;
    logic [NREQ-1:0]      req_wvalid;
    logic [NREQ-1:0]      req_wready;
    logic [NREQ-1:0]      req_bvalid;
    logic [1:0]           req_bresp;
    logic [NREQ-1:0]      req_bready;
    logic [AW-1:0]        m_axi_awaddr;
    logic [7:0]           m_axi_awlen;
    logic [2:0]           m_axi_awsize;
    logic [1:0]           m_axi_awburst;
    logic                 m_axi_awvalid;
    logic                 m_axi_awready;
    logic [DW-1:0]        m_axi_wdata;
    logic [SW-1:0]        m_axi_wstrb;
    logic                 m_axi_wlast;
    logic                 m_axi_wvalid;
    logic                 m_axi_wready;
    logic [1:0]           m_axi_bresp;
    logic                 m_axi_bvalid;
    logic                 m_axi_bready;
    logic [NREQ-1:0]      grant;

    int n_checks = 0;
    int n_fail   = 0;

    axi_wr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_awaddr    (req_awaddr),
        .req_awlen     (req_awlen),
        .req_awsize    (req_awsize),
        .req_awburst   (req_awburst),
        .req_awvalid   (req_awvalid),
        .req_awready   (req_awready),
        .req_wdata     (req_wdata),
        .req_wstrb     (req_wstrb),
        .req_wvalid    (req_wvalid),
        .req_wready    (req_wready),
        .req_bvalid    (req_bvalid),
        .req_bresp     (req_bresp),
        .req_bready    (req_bready),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awlen   (m_axi_awlen),
        .m_axi_awsize  (m_axi_awsize),
        .m_axi_awburst (m_axi_awburst),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wlast   (m_axi_wlast),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready),
        .grant         (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 2 time units after the next rising edge (drive point).
    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs;
        req_awaddr    = '0;
        req_awlen     = '0;
        req_awsize    = '0;
        req_awburst   = '0;
        req_awvalid   = '0;
        req_wdata     = '0;
        req_wstrb     = '0;
        req_wvalid    = '0;
        req_bready    = '0;
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b0;
        m_axi_bresp   = 2'b00;
        m_axi_bvalid  = 1'b0;
    endtask

    task automatic apply_reset;
        clear_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    // Reset holds every valid/ready low even with all inputs asserted.
    task automatic test_reset;
        clear_inputs();
        rst = 1'b1;
        req_awvalid   = '1;
        req_wvalid    = '1;
        req_bready    = '1;
        m_axi_awready = 1'b1;
        m_axi_wready  = 1'b1;
        m_axi_bvalid  = 1'b1;
        step();
        #1;
        n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b expected 0000", grant); end
        n_checks++; if (m_axi_awvalid !== 1'b0) begin n_fail++; $display("FAIL reset_awvalid: got %b expected 0", m_axi_awvalid); end
        n_checks++; if (m_axi_wvalid !== 1'b0) begin n_fail++; $display("FAIL reset_wvalid: got %b expected 0", m_axi_wvalid); end
        n_checks++; if (m_axi_bready !== 1'b0) begin n_fail++; $display("FAIL reset_bready: got %b expected 0", m_axi_bready); end
        n_checks++; if (req_awready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_awready: got %b expected 0000", req_awready); end
        n_checks++; if (req_wready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_wready: got %b expected 0000", req_wready); end
        n_checks++; if (req_bvalid !== 4'b0000) begin n_fail++; $display("FAIL reset_req_bvalid: got %b expected 0000", req_bvalid); end
        n_checks++; if (m_axi_wlast !== 1'b0) begin n_fail++; $display("FAIL reset_wlast: got %b expected 0", m_axi_wlast); end
        clear_inputs();
        step();
        rst = 1'b0;
        step();
    endtask

    // Requester 1, awlen=3, all slave readies high.
    task automatic test_single;
        clear_inputs();
        req_awaddr[1*AW +: AW] = 32'h1000_0040;
        req_awlen[1*8 +: 8]    = 8'd3;
        req_awsize[1*3 +: 3]   = 3'd3;
        req_awburst[1*2 +: 2]  = 2'b01;
        req_awvalid   = 4'b0010;
        req_wvalid    = 4'b0010;
        req_bready    = 4'b0010;
        m_axi_awready = 1'b1;
        m_axi_wready  = 1'b1;
        #1;
        n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL single_grant_c0: got %b expected 0000", grant); end
        step();
        #1;
        n_checks++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL single_grant_c1: got %b expected 0010", grant); end
        n_checks++; if (m_axi_awvalid !== 1'b1) begin n_fail++; $display("FAIL single_awvalid: got %b expected 1", m_axi_awvalid); end
        n_checks++; if (m_axi_awaddr !== 32'h1000_0040) begin n_fail++; $display("FAIL single_awaddr: got %h expected 10000040", m_axi_awaddr); end
        n_checks++; if (m_axi_awlen !== 8'd3) begin n_fail++; $display("FAIL single_awlen: got %0d expected 3", m_axi_awlen); end
        n_checks++; if (req_awready !== 4'b0010) begin n_fail++; $display("FAIL single_req_awready: got %b expected 0010", req_awready); end
        n_checks++; if (m_axi_wvalid !== 1'b0) begin n_fail++; $display("FAIL single_wvalid_in_addr: got %b expected 0", m_axi_wvalid); end
        step();
        req_awvalid = '0;
        for (int b = 0; b < 4; b++) begin
            req_wdata[1*DW +: DW] = 64'hA5A5_0000_0000_0000 | 64'(b);
            #1;
            n_checks++; if (m_axi_wvalid !== 1'b1) begin n_fail++; $display("FAIL single_wvalid_beat%0d: got %b expected 1", b, m_axi_wvalid); end
            n_checks++; if (m_axi_wlast !== (b == 3)) begin n_fail++; $display("FAIL single_wlast_beat%0d: got %b expected %b", b, m_axi_wlast, (b == 3)); end
            n_checks++; if (m_axi_wdata !== (64'hA5A5_0000_0000_0000 | 64'(b))) begin n_fail++; $display("FAIL single_wdata_beat%0d: got %h", b, m_axi_wdata); end
            n_checks++; if (req_wready !== 4'b0010) begin n_fail++; $display("FAIL single_req_wready_beat%0d: got %b expected 0010", b, req_wready); end
            step();
        end
        req_wvalid   = '0;
        m_axi_bvalid = 1'b1;
        m_axi_bresp  = 2'b00;
        #1;
        n_checks++; if (req_bvalid !== 4'b0010) begin n_fail++; $display("FAIL single_req_bvalid: got %b expected 0010", req_bvalid); end
        n_checks++; if (m_axi_bready !== 1'b1) begin n_fail++; $display("FAIL single_bready: got %b expected 1", m_axi_bready); end
        step();
        m_axi_bvalid = 1'b0;
        #1;
        n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL single_grant_after: got %b expected 0000", grant); end
        n_checks++; if (req_bvalid !== 4'b0000) begin n_fail++; $display("FAIL single_req_bvalid_after: got %b expected 0000", req_bvalid); end
    endtask

    // All four requesting continuously with awlen=0: grant order, 3-cycle
    // ownership and a single idle cycle between transactions.
    task automatic test_round_robin;
        int exp_idx [5];
        int gap;
        int held;
`ifdef AXI_WR_ARB_FIXED_PRIO_EN
        exp_idx = '{0, 0, 0, 0, 0};
`else
        exp_idx = '{0, 1, 2, 3, 0};
`endif
        apply_reset();
        req_awvalid   = '1;
        req_wvalid    = '1;
        req_bready    = '1;
        m_axi_awready = 1'b1;
        m_axi_wready  = 1'b1;
        m_axi_bvalid  = 1'b1;
        #1;
        for (int t = 0; t < 5; t++) begin
            gap = 0;
            while (grant === 4'b0000 && gap < 20) begin
                @(posedge clk);
                #3;
                gap++;
            end
            n_checks++;
            if (gap >= 20) begin
                n_fail++;
                $display("FAIL rr_wait_grant%0d: no grant within 20 cycles", t);
                clear_inputs();
                return;
            end
            n_checks++; if (gap !== 1) begin n_fail++; $display("FAIL rr_gap%0d: got %0d idle cycles expected 1", t, gap); end
            n_checks++; if (grant !== (4'b0001 << exp_idx[t])) begin n_fail++; $display("FAIL rr_order%0d: got %b expected requester %0d", t, grant, exp_idx[t]); end
            held = 0;
            while (grant !== 4'b0000 && held < 20) begin
                @(posedge clk);
                #3;
                held++;
            end
            n_checks++; if (held !== 3) begin n_fail++; $display("FAIL rr_held%0d: got %0d cycles expected 3", t, held); end
        end
        clear_inputs();
        step();
    endtask

    // Requester 2, awlen=255, wready toggling every cycle. Leaves the
    // arbiter in RESP for the following test.
    task automatic test_long_burst;
        int  beats;
        int  wlast_bad;
        int  cyc;
        bit  done;
        clear_inputs();
        req_awvalid         = 4'b0100;
        req_awlen[2*8 +: 8] = 8'd255;
        req_wvalid          = 4'b0100;
        m_axi_awready       = 1'b1;
        step();
        #1;
        n_checks++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL long_grant: got %b expected 0100", grant); end
        n_checks++; if (m_axi_wvalid !== 1'b0) begin n_fail++; $display("FAIL long_early_wvalid: got %b expected 0", m_axi_wvalid); end
        n_checks++; if (req_wready !== 4'b0000) begin n_fail++; $display("FAIL long_early_wready: got %b expected 0000", req_wready); end
        step();
        req_awvalid = '0;
        beats = 0;
        wlast_bad = 0;
        cyc = 0;
        done = 1'b0;
        while (!done && cyc < 1000) begin
            m_axi_wready = ~m_axi_wready;
            #1;
            if (m_axi_wvalid === 1'b1) begin
                if (m_axi_wlast !== (beats == 255)) wlast_bad++;
                if (m_axi_wready) begin
                    beats++;
                    if (m_axi_wlast === 1'b1) done = 1'b1;
                end
            end
            step();
            cyc++;
        end
        req_wvalid   = '0;
        m_axi_wready = 1'b0;
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL long_wlast_seen: got %b expected 1", done); end
        n_checks++; if (beats !== 256) begin n_fail++; $display("FAIL long_beats: got %0d expected 256", beats); end
        n_checks++; if (wlast_bad !== 0) begin n_fail++; $display("FAIL long_wlast_position: got %0d bad beats expected 0", wlast_bad); end
        #1;
        n_checks++; if (m_axi_wvalid !== 1'b0) begin n_fail++; $display("FAIL long_wvalid_in_resp: got %b expected 0", m_axi_wvalid); end
    endtask

    // B response held 5 cycles with req_bready low: no bready, no release.
    task automatic test_bresp_hold;
        m_axi_bvalid = 1'b1;
        req_bready   = '0;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_checks++; if (m_axi_bready !== 1'b0) begin n_fail++; $display("FAIL hold_bready%0d: got %b expected 0", k, m_axi_bready); end
            n_checks++; if (req_bvalid !== 4'b0100) begin n_fail++; $display("FAIL hold_req_bvalid%0d: got %b expected 0100", k, req_bvalid); end
            n_checks++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL hold_grant%0d: got %b expected 0100", k, grant); end
            step();
        end
        req_bready = 4'b0100;
        #1;
        n_checks++; if (m_axi_bready !== 1'b1) begin n_fail++; $display("FAIL hold_release_bready: got %b expected 1", m_axi_bready); end
        step();
        clear_inputs();
        #1;
        n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL hold_grant_after: got %b expected 0000", grant); end
    endtask

    // Reset after two beats of an 8-beat burst, then a fresh request.
    task automatic test_reset_mid;
        clear_inputs();
        req_awvalid         = 4'b0001;
        req_awlen[0*8 +: 8] = 8'd7;
        req_wvalid          = 4'b0001;
        m_axi_awready       = 1'b1;
        m_axi_wready        = 1'b1;
        step();
        step();
        req_awvalid = '0;
        step();
        step();
        m_axi_bvalid = 1'b1;
        req_bready   = '1;
        rst          = 1'b1;
        #1;
        n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL rstmid_grant: got %b expected 0000", grant); end
        n_checks++; if (m_axi_wvalid !== 1'b0) begin n_fail++; $display("FAIL rstmid_wvalid: got %b expected 0", m_axi_wvalid); end
        n_checks++; if (req_wready !== 4'b0000) begin n_fail++; $display("FAIL rstmid_req_wready: got %b expected 0000", req_wready); end
        n_checks++; if (m_axi_wlast !== 1'b0) begin n_fail++; $display("FAIL rstmid_wlast: got %b expected 0", m_axi_wlast); end
        n_checks++; if (req_bvalid !== 4'b0000) begin n_fail++; $display("FAIL rstmid_req_bvalid: got %b expected 0000", req_bvalid); end
        n_checks++; if (m_axi_bready !== 1'b0) begin n_fail++; $display("FAIL rstmid_bready: got %b expected 0", m_axi_bready); end
        rst = 1'b0;
        clear_inputs();
        req_awvalid   = 4'b0010;
        req_wvalid    = 4'b0010;
        req_bready    = 4'b0010;
        m_axi_awready = 1'b1;
        m_axi_wready  = 1'b1;
        step();
        #1;
        n_checks++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL rstmid_regrant: got %b expected 0010", grant); end
        n_checks++; if (m_axi_awvalid !== 1'b1) begin n_fail++; $display("FAIL rstmid_reawvalid: got %b expected 1", m_axi_awvalid); end
        step();
        req_awvalid = '0;
        step();
        m_axi_bvalid = 1'b1;
        step();
        clear_inputs();
        #1;
        n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL rstmid_done: got %b expected 0000", grant); end
    endtask

    // SLVERR passes through to requester 3 only; completion as for OKAY.
    task automatic test_slverr;
        clear_inputs();
        req_awvalid   = 4'b1000;
        req_wvalid    = 4'b1000;
        m_axi_awready = 1'b1;
        m_axi_wready  = 1'b1;
        step();
        step();
        req_awvalid = '0;
        step();
        req_wvalid   = '0;
        m_axi_bvalid = 1'b1;
        m_axi_bresp  = 2'b10;
        req_bready   = 4'b1000;
        #1;
        n_checks++; if (req_bvalid !== 4'b1000) begin n_fail++; $display("FAIL slverr_req_bvalid: got %b expected 1000", req_bvalid); end
        n_checks++; if (req_bresp !== 2'b10) begin n_fail++; $display("FAIL slverr_req_bresp: got %b expected 10", req_bresp); end
        n_checks++; if (m_axi_bready !== 1'b1) begin n_fail++; $display("FAIL slverr_bready: got %b expected 1", m_axi_bready); end
        step();
        #1;
        n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL slverr_grant_after: got %b expected 0000", grant); end
        n_checks++; if (req_bvalid !== 4'b0000) begin n_fail++; $display("FAIL slverr_req_bvalid_after: got %b expected 0000", req_bvalid); end
        clear_inputs();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_single();
        test_round_robin();
        test_long_burst();
        test_bresp_hold();
        test_reset_mid();
        test_slverr();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard stop if the sequence above ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/axi_wr_arbiter.md
# axi_wr_arbiter

Round-robin arbiter sharing one AXI write master port (AW/W/B) between `NREQ` requesters. It sits in front of the write slave and owns the channel for a whole transaction: address, burst and response. It grants exactly one requester at a time, muxes that requester onto the shared channel, generates `wlast` from its own beat counter, and routes the B response back to the granted requester only.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `AW`, 32: address width.
- `DW`, 64: data width; strobe width is `DW/8`.

Ports:
- `clk` in 1: clock; all logic on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_awaddr` in NREQ*AW: per-requester address, flattened; requester i at [i*AW +: AW].
- `req_awlen` in NREQ*8: burst length minus 1.
- `req_awsize` in NREQ*3, `req_awburst` in NREQ*2: burst size and type.
- `req_awvalid` in NREQ: address request per requester.
- `req_awready` out NREQ: address accepted.
- `req_wdata` in NREQ*DW, `req_wstrb` in NREQ*DW/8, `req_wvalid` in NREQ: write data.
- `req_wready` out NREQ: data accepted.
- `req_bvalid` out NREQ, `req_bresp` out 2: response to the granted requester.
- `req_bready` in NREQ: requester accepts response.
- `m_axi_awaddr/awlen/awsize/awburst/awvalid` out: shared AW channel.
- `m_axi_awready` in 1.
- `m_axi_wdata/wstrb/wlast/wvalid` out: shared W channel.
- `m_axi_wready` in 1.
- `m_axi_bresp` in 2, `m_axi_bvalid` in 1.
- `m_axi_bready` out 1.
- `grant` out NREQ: one-hot current owner, all-zero when idle.

## Operation
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE: if any `req_awvalid`, pick the winner by round-robin starting at `ptr`, latch the one-hot `grant`, go to ADDR. No channel outputs are asserted.
- ADDR: the granted requester's AW fields are muxed combinationally to `m_axi_aw*`, and `m_axi_awready` is routed to its `req_awready`. On `awvalid && awready`, latch `awlen` into `len_q`, clear `beat`, and go to DATA.
- DATA: the granted W signals are muxed through. `m_axi_wlast = (beat == len_q)`. Each W handshake increments `beat`. A handshake with `wlast` goes to RESP.
- RESP: `req_bvalid[g] = m_axi_bvalid`, `req_bresp = m_axi_bresp`, `m_axi_bready = req_bready[g]`. On the B handshake: clear `grant`, set `ptr` to g+1 mod NREQ, go to IDLE.
- Non-granted requesters see ready/bvalid held at 0 at all times.
- `beat` is 8 bits and is compared against the 8-bit `len_q`. `awlen`=255 gives 256 beats with no wrap before `wlast`.
- Requesters must hold `awvalid` until ready. A requester that drops `awvalid` while in ADDR is not released: the arbiter waits.
- A requester asserting `wvalid` before its AW handshake is ignored until DATA.

## Timing
- Grant latency: `req_awvalid` at cycle 0 in IDLE gives `grant` and `m_axi_awvalid` at cycle 1.
- Minimum transaction is 4 cycles for a single beat: IDLE→ADDR→DATA→RESP, with a 1-cycle handshake in each state.
- Back-to-back transactions: the cycle after the B handshake is IDLE, and the next grant is visible one cycle after that.
- Reset values: `grant`=0, `ptr`=0, state IDLE, `beat`=0, `len_q`=0. All `m_axi_*valid`, `m_axi_bready`, `req_*ready` and `req_bvalid` are 0.
- Reset mid-transaction returns to IDLE asynchronously. No response is delivered to the abandoned requester.
- Simultaneous requests are resolved in the same IDLE cycle by `ptr` order.
- SLVERR/DECERR pass through unchanged, and completion is identical to OKAY.

## Configuration
- `AXI_WR_ARB_FIXED_PRIO_EN`
  - Defined: fixed priority, lowest index wins; `ptr` is not implemented.
  - Undefined (default): round-robin as described above.

## Structure
- Shared package `axi_wr_arb_pkg`: state enum (IDLE/ADDR/DATA/RESP) and AXI response constants OKAY=2'b00, SLVERR=2'b10.
- Sub-module `rr_pick`: combinational one-hot picker taking the request vector and `ptr`. Under the macro it becomes a priority encoder.

## Test plan
- Single requester 1, `awlen`=3, `m_axi_*ready` tied high → `grant`=4'b0010 at cycle 1; 4 W beats with `wlast` only on beat 4; `req_bvalid[1]` asserted; `grant`=0 afterwards.
- All 4 requesting continuously with `awlen`=0 → grant order 0,1,2,3,0. With the macro defined, requester 0 wins every time.
- `awlen`=255 with `m_axi_wready` toggling every cycle → exactly 256 beats, `wlast` only on the last.
- `m_axi_bvalid` held 5 cycles with `req_bready` low → `m_axi_bready`=0 and the state stays RESP until `req_bready`=1.
- Assert `rst` in DATA after 2 beats → all outputs 0 immediately; a new request is granted normally afterwards.
- `m_axi_bresp`=2'b10 → `req_bresp`=2'b10 to the granted requester only; the arbiter returns to IDLE.
